// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges ALU results and buffered load results
// into one registered write per cycle, with bounded starvation of the load FIFO.
module wb_arbiter #(
  parameter int N        = 64,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_wa,
  input  logic [N-1:0]             alu_wd,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_wa,
  input  logic [N-1:0]             mem_wd,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [N-1:0]             wd3,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);
  localparam logic [4:0]    XZR        = 5'd31;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO
  } sel_t;

  logic [4:0]    r_fifo_wa [DEPTH];
  logic [N-1:0]  r_fifo_wd [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [WW-1:0] r_wait;
  logic          r_we3;
  logic [4:0]    r_wa3;
  logic [N-1:0]  r_wd3;

  logic          w_empty;
  logic          w_force;
  logic          w_alu_fire;
  logic          w_mem_fire;
  logic          w_alu_write;
  logic          w_push;
  logic          w_pop;
  sel_t          w_sel;
  logic [AW:0]   w_count_next;
  logic [WW-1:0] w_wait_next;

  assign w_empty     = (r_count == '0);
  assign w_force     = (r_wait == MAX_WAIT_C) && !w_empty;
  assign alu_ready   = !w_force;
  // No pass-through: a full FIFO refuses loads even on a cycle it pops.
  assign mem_ready   = (r_count < DEPTH_C);
  assign w_alu_fire  = alu_valid && alu_ready;
  assign w_mem_fire  = mem_valid && mem_ready;
  assign w_alu_write = w_alu_fire && (alu_wa != XZR);
  assign w_push      = w_mem_fire && (mem_wa != XZR);

  always_comb begin
    w_sel = SEL_NONE;
    if (w_force) begin
      w_sel = SEL_FIFO;
    end else if (w_alu_write) begin
      w_sel = SEL_ALU;
    end else if (!w_empty) begin
      w_sel = SEL_FIFO;
    end
  end

  assign w_pop = (w_sel == SEL_FIFO);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_wait_next = r_wait;
    if (w_pop || w_empty) begin
      w_wait_next = '0;
    end else if (r_wait != MAX_WAIT_C) begin
      w_wait_next = r_wait + 1'b1;
    end
  end

  // Payload storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr] <= mem_wa;
      r_fifo_wd[r_wr_ptr] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_wait  <= w_wait_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          r_we3 <= 1'b1;
          r_wa3 <= alu_wa;
          r_wd3 <= alu_wd;
        end
        SEL_FIFO: begin
          r_we3 <= 1'b1;
          r_wa3 <= r_fifo_wa[r_rd_ptr];
          r_wd3 <= r_fifo_wd[r_rd_ptr];
        end
        default: r_we3 <= 1'b0;
      endcase
    end
  end

  assign we3     = r_we3;
  assign wa3     = r_wa3;
  assign wd3     = r_wd3;
  assign pending = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, ALU path, XZR filter,
// FIFO fill/order, starvation drain, pointer wrap and mid-run reset.
module tb_wb_arbiter;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_wa;
  logic [N-1:0]  alu_wd;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_wa;
  logic [N-1:0]  mem_wd;
  logic          we3;
  logic [4:0]    wa3;
  logic [N-1:0]  wd3;
  logic [2:0]    pending;

  int n_pass  = 0;
  int n_total = 0;

  wb_arbiter #(.N(N), .DEPTH(4), .MAX_WAIT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] awa, input logic [N-1:0] awd,
                       input logic mv, input logic [4:0] mwa, input logic [N-1:0] mwd);
    alu_valid = av;
    alu_wa    = awa;
    alu_wd    = awd;
    mem_valid = mv;
    mem_wa    = mwa;
    mem_wd    = mwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] ld_data(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h0000_F000 + 32'(i)};
  endfunction

  logic [4:0] wrap_wa [10];

  initial begin
    wrap_wa = '{5'd4, 5'd9, 5'd17, 5'd22, 5'd30, 5'd0, 5'd1, 5'd15, 5'd28, 5'd6};

    // Reset with random inputs
    reset = 1'b0;
    drive(1'($urandom), 5'($urandom), {$urandom, $urandom}, 1'($urandom), 5'($urandom), {$urandom, $urandom});
    repeat (2) begin
      tick();
      drive(1'($urandom), 5'($urandom), {$urandom, $urandom}, 1'($urandom), 5'($urandom), {$urandom, $urandom});
    end
    check_eq("rst_we3", we3, 0);
    check_eq("rst_wd3", wd3, 0);
    check_eq("rst_pending", pending, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    check_eq("rst_alu_ready", alu_ready, 1);
    check_eq("rst_mem_ready", mem_ready, 1);
    tick();
    check_eq("idle_we3", we3, 0);
    $display("reset/idle done");

    // ALU only
    drive(1, 5'd5, 64'h1234, 0, 0, 0);
    tick();
    check_eq("alu_we3", we3, 1);
    check_eq("alu_wa3", wa3, 5);
    check_eq("alu_wd3", wd3, 64'h1234);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check_eq("alu_we3_after", we3, 0);
    check_eq("alu_wa3_hold", wa3, 5);
    $display("alu single write: wa3=%0d wd3=0x%0h", wa3, wd3);

    // XZR discard on both sources
    drive(1, 5'd31, 64'hBAD1, 1, 5'd31, 64'hBAD2);
    check_eq("x31_alu_ready", alu_ready, 1);
    check_eq("x31_mem_ready", mem_ready, 1);
    tick();
    check_eq("x31_we3", we3, 0);
    check_eq("x31_pending", pending, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check_eq("x31_we3_late", we3, 0);
    $display("x31 discard: we3=%0d pending=%0d", we3, pending);

    // Fill FIFO while ALU holds the port
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd1, 64'(k), 1, 5'(10 + k), 64'h5000 + 64'(k));
      check_eq($sformatf("fill%0d_mem_ready", k), mem_ready, 1);
      check_eq($sformatf("fill%0d_alu_ready", k), alu_ready, 1);
      tick();
      check_eq($sformatf("fill%0d_wa3", k), wa3, 1);
      $display("fill %0d: we3=%0d wa3=%0d pending=%0d", k, we3, wa3, pending);
    end
    drive(0, 0, 0, 0, 0, 0);
    check_eq("full_pending", pending, 4);
    check_eq("full_mem_ready", mem_ready, 0);
    check_eq("full_force", alu_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("drain%0d_we3", k), we3, 1);
      check_eq($sformatf("drain%0d_wa3", k), wa3, 64'(10 + k));
      check_eq($sformatf("drain%0d_wd3", k), wd3, 64'h5000 + 64'(k));
      $display("drain %0d: wa3=%0d wd3=0x%0h", k, wa3, wd3);
    end
    check_eq("drain_pending", pending, 0);
    tick();
    check_eq("drain_idle_we3", we3, 0);

    // Starvation: ALU streams, one load forced out after MAX_WAIT blocked cycles
    drive(1, 5'd2, 64'h200, 1, 5'd7, 64'hAA);
    tick();
    check_eq("starve0_wa3", wa3, 2);
    for (int c = 1; c < 4; c++) begin
      drive(1, 5'd2, 64'h200 + 64'(c), 0, 0, 0);
      check_eq($sformatf("starve%0d_alu_ready", c), alu_ready, 1);
      tick();
      check_eq($sformatf("starve%0d_wd3", c), wd3, 64'h200 + 64'(c));
    end
    drive(1, 5'd2, 64'h204, 0, 0, 0);
    check_eq("starve4_alu_ready", alu_ready, 0);
    tick();
    check_eq("starve_drain_we3", we3, 1);
    check_eq("starve_drain_wa3", wa3, 7);
    check_eq("starve_drain_wd3", wd3, 64'hAA);
    $display("starvation drain: wa3=%0d wd3=0x%0h", wa3, wd3);
    check_eq("starve5_alu_ready", alu_ready, 1);
    tick();
    check_eq("starve_resume_wa3", wa3, 2);
    check_eq("starve_resume_wd3", wd3, 64'h204);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check_eq("starve_idle_we3", we3, 0);

    // Wrap-around with push/pop at pending=2
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        drive(c < 2, 5'd3, 64'h300 + 64'(c), 1, wrap_wa[c], ld_data(c));
        check_eq($sformatf("wrap%0d_mem_ready", c), mem_ready, 1);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      check_eq($sformatf("wrap%0d_pending", c), pending,
               (c == 0) ? 0 : (c == 1) ? 1 : (c == 11) ? 1 : 2);
      tick();
      check_eq($sformatf("wrap%0d_we3", c), we3, 1);
      if (c < 2) begin
        check_eq($sformatf("wrap%0d_wa3", c), wa3, 3);
      end else begin
        check_eq($sformatf("wrap%0d_wa3", c), wa3, 64'(wrap_wa[c - 2]));
        check_eq($sformatf("wrap%0d_wd3", c), wd3, ld_data(c - 2));
      end
      $display("wrap %0d: wa3=%0d wd3=0x%0h pending=%0d", c, wa3, wd3, pending);
    end
    check_eq("wrap_end_pending", pending, 0);

    // Asynchronous reset mid-operation drops buffered loads
    drive(1, 5'd4, 64'h44, 1, 5'd8, 64'h88);
    tick();
    check_eq("mid_pending", pending, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_pending", pending, 0);
    check_eq("mid_rst_we3", we3, 0);
    check_eq("mid_rst_wa3", wa3, 0);
    reset = 1'b1;
    tick();
    check_eq("mid_after_we3", we3, 0);
    check_eq("mid_after_pending", pending, 0);
    $display("mid reset: pending=%0d we3=%0d", pending, we3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writer side of the 64-bit register file write port (we3/wa3/wd3). It merges ALU results and asynchronously returning memory-load results into one registered write per cycle. Load results are buffered in a small FIFO. ALU results have priority, but a starvation counter forces the FIFO head out after a bounded wait. Writes addressed to X31 (XZR) are discarded here, so they never occupy the port.

Parameters:
N, 64, data width of write data.
DEPTH, 4, load-result FIFO entries (power of 2, >=2).
MAX_WAIT, 3, consecutive cycles the FIFO head may be blocked before a forced drain (>=1).

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
alu_valid  in  1  ALU result present this cycle
alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
alu_wa  in  5  ALU destination register
alu_wd  in  N  ALU result data
mem_valid  in  1  load result present
mem_ready  out  1  load result accepted when mem_valid & mem_ready
mem_wa  in  5  load destination register
mem_wd  in  N  load data
we3  out  1  register file write enable (registered)
wa3  out  5  register file write address (registered)
wd3  out  N  register file write data (registered)
pending  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): we3=0, wa3=0, wd3=0, FIFO empty, pending=0, wait counter=0. mem_ready=1 and alu_ready=1 once reset deasserts. Reset mid-operation drops all buffered loads.
- Fire conditions: alu_fire = alu_valid & alu_ready; mem_fire = mem_valid & mem_ready.
- X31 filter: a fired source with wa=31 is consumed (handshake completes) but is never written and never enqueued.
- force_drain (combinational) = (wait_cnt == MAX_WAIT) & FIFO non-empty.
- alu_ready = !force_drain.
- mem_ready = (pending < DEPTH). There is no same-cycle pass-through when full; a full FIFO deasserts mem_ready even if it is popping that cycle.
- Per-cycle selection, in priority order:
  1. force_drain -> pop FIFO head.
  2. alu_fire with alu_wa != 31 -> ALU result.
  3. FIFO non-empty -> pop head.
  4. Otherwise no write.
- Output register: next cycle we3=1 with the selected wa/wd; otherwise we3=0. wa3/wd3 hold their last value when we3=0.
- Latency:
  - ALU result reaches we3 1 cycle after alu_fire.
  - A load is written at the earliest 2 cycles after mem_fire (enqueue, then pop).
- FIFO: circular, write pointer and read pointer wrap modulo DEPTH. Push (mem_fire, wa != 31) and pop in the same cycle are allowed; pending is unchanged. Popping an empty FIFO never happens.
- wait_cnt:
  - Increments when the FIFO is non-empty and not popped, saturating at MAX_WAIT.
  - Cleared on any pop, or when the FIFO is empty.
- Ordering between the ALU and load sources to the same register is not enforced here. The hazard unit guarantees no overlapping in-flight destinations. Loads are written in acceptance order.
- The register file forwards wd3 combinationally, so writes issued by this block are visible to same-cycle reads of wa3.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles with random inputs, then release -> we3=0, pending=0, mem_ready=1, alu_ready=1.
- ALU only: alu_valid=1, alu_wa=5, alu_wd=0x1234 for 1 cycle -> next cycle we3=1, wa3=5, wd3=0x1234; the cycle after, we3=0.
- X31 discard: ALU wa=31 and a load with wa=31 both fire -> we3 stays 0, pending stays 0, both handshakes complete.
- Load buffering and full: with alu_valid held 1 (wa=1), send 4 loads wa=10..13 in back-to-back cycles -> pending reaches 4, mem_ready=0. Order written: 10, 11, 12, 13.
- Starvation: ALU streams continuously (wa=2); one load wa=7, data 0xAA, arrives -> after MAX_WAIT=3 blocked cycles, alu_ready=0 for exactly 1 cycle. Next cycle we3=1, wa3=7, wd3=0xAA. ALU writes resume after.
- Simultaneous push/pop at pending=2, wrap-around: 10 mixed loads with the ALU idle -> pointers wrap, all 10 written in order, pending never exceeds 2, no data lost.
